// File: rtl/fp_align_if.sv
// fp_align_if: operand-in / aligned-result-out handshake bundle for fp_align_unit
//   master drives in_valid, X, Y, out_ready; slave (the aligner) drives the rest.
interface fp_align_if #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 7
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   X;
    logic [EXP_W+MAN_W:0]   Y;
    logic                   out_valid;
    logic                   out_ready;
    logic                   Xs_o;
    logic                   Ys_o;
    logic [MAN_W:0]         Xm_al;
    logic [MAN_W:0]         Ym_al;
    logic                   XeLTYe;
    logic [EXP_W-1:0]       Ge;
    logic                   sticky;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, Xs_o, Ys_o, Xm_al, Ym_al, XeLTYe, Ge, sticky
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, Xs_o, Ys_o, Xm_al, Ym_al, XeLTYe, Ge, sticky
    );
endinterface

// File: rtl/fp_align_unit.sv
// fp_align_unit: mini-float pre-add alignment, shifts the smaller significand one bit per cycle
//   clk, rst_n (async, active-low)
//   bus.slave: in_valid/in_ready + X/Y operands {s,e,f}; out_valid/out_ready + Xs_o, Ys_o,
//              Xm_al, Ym_al, XeLTYe, Ge (max exponent), sticky (OR of shifted-out bits)
module fp_align_unit #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 7
) (
    input logic     clk,
    input logic     rst_n,
    fp_align_if.slave bus
);
    localparam int SW = MAN_W + 1;
    localparam logic [EXP_W-1:0] SW_E = EXP_W'(SW);
    localparam logic [EXP_W-1:0] ONE  = EXP_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [EXP_W-1:0] count;
    logic [EXP_W-1:0] xe;
    logic [EXP_W-1:0] ye;
    logic [EXP_W-1:0] diff;
    logic [SW-1:0]    xm_in;
    logic [SW-1:0]    ym_in;
    logic [SW-1:0]    xm;
    logic [SW-1:0]    ym;
    logic [EXP_W-1:0] ge;
    logic             x_lt;
    logic             xs;
    logic             ys;
    logic             lt;
    logic             st;
    logic             ov;

    assign xe    = bus.X[MAN_W +: EXP_W];
    assign ye    = bus.Y[MAN_W +: EXP_W];
    // hidden bit is set for any non-zero exponent; exp==0 gets no denormal adjustment
    assign xm_in = {|xe, bus.X[MAN_W-1:0]};
    assign ym_in = {|ye, bus.Y[MAN_W-1:0]};
    assign x_lt  = xe < ye;
    assign diff  = x_lt ? ye - xe : xe - ye;

    assign bus.in_ready  = (state == IDLE) & rst_n;
    assign bus.out_valid = ov;
    assign bus.Xs_o      = xs;
    assign bus.Ys_o      = ys;
    assign bus.Xm_al     = xm;
    assign bus.Ym_al     = ym;
    assign bus.XeLTYe    = lt;
    assign bus.Ge        = ge;
    assign bus.sticky    = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            xs    <= 1'b0;
            ys    <= 1'b0;
            xm    <= '0;
            ym    <= '0;
            lt    <= 1'b0;
            ge    <= '0;
            st    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state <= SHIFT;
                    xs    <= bus.X[EXP_W+MAN_W];
                    ys    <= bus.Y[EXP_W+MAN_W];
                    lt    <= x_lt;
                    ge    <= x_lt ? ye : xe;
                    // a shift past the whole significand is resolved in one step
                    if (diff > SW_E) begin
                        count <= '0;
                        xm    <= x_lt ? '0 : xm_in;
                        ym    <= x_lt ? ym_in : '0;
                        st    <= x_lt ? |xm_in : |ym_in;
                    end else begin
                        count <= diff;
                        xm    <= xm_in;
                        ym    <= ym_in;
                        st    <= 1'b0;
                    end
                end
                SHIFT: if (count != '0) begin
                    if (lt) begin
                        xm <= xm >> 1;
                        st <= st | xm[0];
                    end else begin
                        ym <= ym >> 1;
                        st <= st | ym[0];
                    end
                    count <= count - ONE;
                end else begin
                    state <= DONE;
                    ov    <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state <= IDLE;
                    ov    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
